// File: rtl/imem_loader_if.sv
// Byte-stream handshake into the instruction-memory loader.
//   RxByte  : image byte from the source
//   RxValid : RxByte is valid this cycle
//   RxReady : loader accepts RxByte; a transfer happens when RxValid & RxReady
// master = byte source, slave = loader.
interface imem_loader_if;
  logic [7:0] RxByte;
  logic       RxValid;
  logic       RxReady;

  modport master (
    output RxByte,
    output RxValid,
    input  RxReady
  );

  modport slave (
    input  RxByte,
    input  RxValid,
    output RxReady
  );
endinterface

// File: rtl/imem_loader.sv
// Instruction-memory loader: receives a byte-serial program image
// (0xA5, word count N, 4*N data bytes, XOR checksum byte), packs bytes into
// 32-bit words, writes them into a 2^ADDR_W-word RAM and holds the core
// until an image with a good checksum is resident.
// Ports:
//   clk       : clock, all state updates on the rising edge
//   flush_n   : synchronous active-low reset
//   rx        : byte-stream handshake (slave side)
//   RdAddr    : fetch word address
//   RdData    : combinational RAM[RdAddr]
//   CoreHold  : 1 = stall and flush the core
//   LoadDone  : one-cycle pulse when an image passes its checksum
//   LoadErr   : sticky error flag for the last load attempt
//   WordCount : words written in the current or most recent load
module imem_loader #(
  parameter int unsigned ADDR_W     = 6,
  parameter bit          BIG_ENDIAN = 1'b1
) (
  input  logic              clk,
  input  logic              flush_n,
  imem_loader_if.slave      rx,
  input  logic [ADDR_W-1:0] RdAddr,
  output logic [31:0]       RdData,
  output logic              CoreHold,
  output logic              LoadDone,
  output logic              LoadErr,
  output logic [ADDR_W:0]   WordCount
);

  localparam int unsigned Depth = 1 << ADDR_W;
  localparam int unsigned CntW  = ADDR_W + 1;
  localparam logic [8:0]  DepthB = 9'(Depth);
  localparam logic [7:0]  Magic  = 8'hA5;

  typedef enum logic [2:0] {
    StIdle,
    StCount,
    StData,
    StWrite,
    StCsum,
    StRun
  } state_e;

  state_e            state_q, state_d;
  logic [1:0]        byte_cnt_q, byte_cnt_d;
  logic [31:0]       word_q, word_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [CntW-1:0]   count_q, count_d;
  logic [CntW-1:0]   wc_q, wc_d;
  logic [7:0]        csum_q, csum_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  logic              ready;
  logic              xfer;
  logic              mem_we;
  logic              count_ok;
  logic [CntW-1:0]   wc_inc;

  logic [31:0]       mem [Depth];

  // The only cycle the loader refuses a byte is the RAM write cycle.
  assign ready    = (state_q != StWrite);
  assign xfer     = rx.RxValid & ready;
  assign count_ok = (rx.RxByte != 8'd0) && ({1'b0, rx.RxByte} <= DepthB);
  assign wc_inc   = wc_q + CntW'(1);

  always_comb begin
    state_d    = state_q;
    byte_cnt_d = byte_cnt_q;
    word_d     = word_q;
    addr_d     = addr_q;
    count_d    = count_q;
    wc_d       = wc_q;
    csum_d     = csum_q;
    err_d      = err_q;
    done_d     = 1'b0;
    mem_we     = 1'b0;

    unique case (state_q)
      StIdle, StRun: begin
        if (xfer && (rx.RxByte == Magic)) begin
          state_d = StCount;
          err_d   = 1'b0;
          wc_d    = '0;
          csum_d  = '0;
        end
      end
      StCount: begin
        if (xfer) begin
          if (count_ok) begin
            count_d    = CntW'(rx.RxByte);
            addr_d     = '0;
            byte_cnt_d = '0;
            state_d    = StData;
          end else begin
            err_d   = 1'b1;
            state_d = StIdle;
          end
        end
      end
      StData: begin
        if (xfer) begin
          // Shift-in assembler: after four bytes the first one sits in the
          // top byte (big endian) or the bottom byte (little endian).
          if (BIG_ENDIAN) begin
            word_d = {word_q[23:0], rx.RxByte};
          end else begin
            word_d = {rx.RxByte, word_q[31:8]};
          end
          csum_d     = csum_q ^ rx.RxByte;
          byte_cnt_d = byte_cnt_q + 2'd1;
          if (byte_cnt_q == 2'd3) begin
            state_d = StWrite;
          end
        end
      end
      StWrite: begin
        mem_we  = 1'b1;
        addr_d  = addr_q + ADDR_W'(1);
        wc_d    = wc_inc;
        state_d = (wc_inc == count_q) ? StCsum : StData;
      end
      StCsum: begin
        if (xfer) begin
          if (rx.RxByte == csum_q) begin
            done_d  = 1'b1;
            state_d = StRun;
          end else begin
            err_d   = 1'b1;
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!flush_n) begin
      state_q    <= StIdle;
      byte_cnt_q <= '0;
      word_q     <= '0;
      addr_q     <= '0;
      count_q    <= '0;
      wc_q       <= '0;
      csum_q     <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      byte_cnt_q <= byte_cnt_d;
      word_q     <= word_d;
      addr_q     <= addr_d;
      count_q    <= count_d;
      wc_q       <= wc_d;
      csum_q     <= csum_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  // RAM contents survive reset so a partially loaded image stays visible.
  always_ff @(posedge clk) begin
    if (flush_n && mem_we) begin
      mem[addr_q] <= word_q;
    end
  end

  assign RdData     = mem[RdAddr];
  assign rx.RxReady = ready;
  // Derived from the registered state so hold drops in the LoadDone cycle.
  assign CoreHold   = (state_q != StRun);
  assign LoadDone   = done_q;
  assign LoadErr    = err_q;
  assign WordCount  = wc_q;

endmodule
